// File: rtl/sprot_arb_if.sv
// -----------------------------------------------------------------------------
// sprot_arb_if
//   Bundle of the requester-side and checker-side signals of the sprot
//   round-robin arbiter.
//
//   Signals
//     req         requester -> arbiter   level request per requester
//     inj_drop_a  env       -> arbiter   suppress the a phase (sampled at grant)
//     inj_drop_b  env       -> arbiter   suppress the b phase (sampled at grant)
//     gnt         arbiter   -> requester one-hot grant
//     done        arbiter   -> requester 1-cycle transfer-finished pulse
//     err         arbiter   -> requester error flag, valid with done
//     busy        arbiter   -> env       arbiter not idle
//     start/a/b   arbiter   -> checker   protocol strobes
//     prot_err    checker   -> arbiter   protocol error flag
//     xfer_end    checker   -> arbiter   transfer complete
//
//   Modports
//     master  the arbiter (drives the protocol strobes and grant/status)
//     slave   the environment: requesters plus the protocol checker
// -----------------------------------------------------------------------------
interface sprot_arb_if #(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0] req;
  logic               inj_drop_a;
  logic               inj_drop_b;
  logic [NUM_REQ-1:0] gnt;
  logic               done;
  logic               err;
  logic               busy;
  logic               start;
  logic               a;
  logic               b;
  logic               prot_err;
  logic               xfer_end;

  modport master (
    input  req,
    input  inj_drop_a,
    input  inj_drop_b,
    input  prot_err,
    input  xfer_end,
    output gnt,
    output done,
    output err,
    output busy,
    output start,
    output a,
    output b
  );

  modport slave (
    output req,
    output inj_drop_a,
    output inj_drop_b,
    output prot_err,
    output xfer_end,
    input  gnt,
    input  done,
    input  err,
    input  busy,
    input  start,
    input  a,
    input  b
  );

endinterface

// File: rtl/sprot_arb.sv
// -----------------------------------------------------------------------------
// sprot_arb
//   Round-robin arbiter and sequencer for the start/a/b protocol. One sprot
//   port is shared among NUM_REQ requesters. For the granted requester the
//   block issues start, then a, then b (each one cycle), waits for the
//   checker's xfer_end (or a timeout), and returns done/err to the winner.
//   Optional drop flags suppress the a or b strobe for negative coverage.
//
//   Parameters
//     NUM_REQ      number of requesters (2..16)
//     TIMEOUT_CYC  max cycles spent waiting for xfer_end (>= 1)
//     GAP_CYC      idle cycles after a transfer (0 still gives one GAP cycle)
//
//   Ports
//     clk    in   clock, all logic on posedge
//     rst_n  in   synchronous active-low reset
//     bus    sprot_arb_if.master: req, inj_drop_a/b, prot_err, xfer_end in;
//            gnt, done, err, busy, start, a, b out (all registered)
// -----------------------------------------------------------------------------
module sprot_arb #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 8,
  parameter int GAP_CYC     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sprot_arb_if.master bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [PW:0]   NUM_W    = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [TW-1:0] TCNT_END = TW'(TIMEOUT_CYC);
  // Last value of gap_cnt before leaving GAP; GAP_CYC of 0 or 1 both leave
  // after the first GAP cycle.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 1) ? (GAP_CYC - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_A_PH,
    S_B_PH,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [TW-1:0]      tcnt_reg, tcnt_next;
  logic [GW-1:0]      gap_cnt_reg, gap_cnt_next;
  logic               drop_a_reg, drop_a_next;
  logic               drop_b_reg, drop_b_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic               busy_reg, busy_next;
  logic               start_reg, start_next;
  logic               a_reg, a_next;
  logic               b_reg, b_next;

  // ---------------------------------------------------------------------------
  // Round-robin candidate list: candidate gi is requester (rr_ptr + gi) mod
  // NUM_REQ, so candidate 0 has the highest priority.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [PW:0] sum;
      assign sum          = {1'b0, rr_ptr_reg} + (PW+1)'(gi);
      assign cand_idx[gi] = (sum >= NUM_W) ? PW'(sum - NUM_W) : sum[PW-1:0];
      assign cand_req[gi] = bus.req[cand_idx[gi]];
    end
  endgenerate

  logic          win_found;
  logic [PW-1:0] win_idx;

  // Scan from lowest priority to highest so the highest-priority hit is the
  // last assignment and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  logic [TW-1:0] tcnt_inc;
  assign tcnt_inc = tcnt_reg + TW'(1);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are registered copies of values
  // computed for the state being entered, so every output is valid in the
  // same cycle as the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    tcnt_next    = tcnt_reg;
    gap_cnt_next = gap_cnt_reg;
    drop_a_next  = drop_a_reg;
    drop_b_next  = drop_b_reg;
    gnt_next     = gnt_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    start_next   = 1'b0;
    a_next       = 1'b0;
    b_next       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (win_found) begin
          state_next       = S_START;
          gnt_next         = '0;
          gnt_next[win_idx] = 1'b1;
          drop_a_next      = bus.inj_drop_a;
          drop_b_next      = bus.inj_drop_b;
          rr_ptr_next      = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
          start_next       = 1'b1;
        end
      end

      S_START: begin
        state_next = S_A_PH;
        a_next     = ~drop_a_reg;
      end

      S_A_PH: begin
        state_next = S_B_PH;
        b_next     = ~drop_b_reg;
      end

      S_B_PH: begin
        state_next = S_WAIT;
        tcnt_next  = '0;
      end

      S_WAIT: begin
        tcnt_next    = tcnt_inc;
        gap_cnt_next = '0;
        // xfer_end takes precedence over a timeout in the same cycle.
        if (bus.xfer_end) begin
          state_next = S_GAP;
          done_next  = 1'b1;
          err_next   = bus.prot_err;
        end else if (tcnt_inc == TCNT_END) begin
          state_next = S_GAP;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end
      end

      S_GAP: begin
        // gnt stays valid alongside done in the first GAP cycle so the
        // requester can qualify done with its own grant bit.
        gnt_next = '0;
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GW'(1);
        end
      end

      default: begin
        state_next = S_IDLE;
        gnt_next   = '0;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      rr_ptr_reg  <= '0;
      tcnt_reg    <= '0;
      gap_cnt_reg <= '0;
      drop_a_reg  <= 1'b0;
      drop_b_reg  <= 1'b0;
      gnt_reg     <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      start_reg   <= 1'b0;
      a_reg       <= 1'b0;
      b_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      tcnt_reg    <= tcnt_next;
      gap_cnt_reg <= gap_cnt_next;
      drop_a_reg  <= drop_a_next;
      drop_b_reg  <= drop_b_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
      start_reg   <= start_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
    end
  end

  assign bus.gnt   = gnt_reg;
  assign bus.done  = done_reg;
  assign bus.err   = err_reg;
  assign bus.busy  = busy_reg;
  assign bus.start = start_reg;
  assign bus.a     = a_reg;
  assign bus.b     = b_reg;

endmodule

// File: tb/tb_sprot_arb.sv
// -----------------------------------------------------------------------------
// tb_sprot_arb
//   Directed testbench for sprot_arb (NUM_REQ=4, TIMEOUT_CYC=8, GAP_CYC=2).
//   Inputs change 1 time unit after the rising edge and outputs are sampled
//   at the same point, so every sample sees the registers of the cycle just
//   entered. Each task drives one scenario and checks its own results.
// -----------------------------------------------------------------------------
module tb_sprot_arb;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int GAP_CYC     = 2;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  sprot_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  sprot_arb #(
    .NUM_REQ    (NUM_REQ),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // All outputs packed: {gnt[3:0], done, err, busy, start, a, b}
  logic [9:0] outs;
  assign outs = {bus.gnt, bus.done, bus.err, bus.busy, bus.start, bus.a, bus.b};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.req        = 4'b1111;
    bus.inj_drop_a = 1'b0;
    bus.inj_drop_b = 1'b0;
    bus.prot_err   = 1'b0;
    bus.xfer_end   = 1'b0;
    step();
    step();
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", outs, 10'b0);
    end
    bus.req = '0;
    rst_n   = 1'b1;
    step();
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("FAIL idle_no_req got=%b exp=%b", outs, 10'b0);
    end
    $display("reset: outs=%b", outs);
  endtask

  task automatic test_single();
    bus.req = 4'b0010;
    step(); // START
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL single_gnt got=%b exp=%b", bus.gnt, 4'b0010);
    end
    checks++;
    if ({bus.start, bus.a, bus.b, bus.busy} !== 4'b1001) begin
      errors++;
      $display("FAIL single_start got=%b exp=%b", {bus.start, bus.a, bus.b, bus.busy}, 4'b1001);
    end
    bus.req = '0;
    step(); // A_PH
    checks++;
    if ({bus.start, bus.a, bus.b} !== 3'b010) begin
      errors++;
      $display("FAIL single_a got=%b exp=%b", {bus.start, bus.a, bus.b}, 3'b010);
    end
    step(); // B_PH
    checks++;
    if ({bus.start, bus.a, bus.b} !== 3'b001) begin
      errors++;
      $display("FAIL single_b got=%b exp=%b", {bus.start, bus.a, bus.b}, 3'b001);
    end
    step(); // first WAIT cycle
    checks++;
    if ({bus.start, bus.a, bus.b, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL single_wait got=%b exp=%b", {bus.start, bus.a, bus.b, bus.done}, 4'b0000);
    end
    bus.xfer_end = 1'b1;
    bus.prot_err = 1'b0;
    step(); // first GAP cycle
    bus.xfer_end = 1'b0;
    checks++;
    if ({bus.done, bus.err, bus.gnt} !== 6'b10_0010) begin
      errors++;
      $display("FAIL single_done got=%b exp=%b", {bus.done, bus.err, bus.gnt}, 6'b10_0010);
    end
    step(); // second GAP cycle
    checks++;
    if ({bus.done, bus.busy, bus.gnt} !== 6'b01_0000) begin
      errors++;
      $display("FAIL single_gap2 got=%b exp=%b", {bus.done, bus.busy, bus.gnt}, 6'b01_0000);
    end
    step(); // IDLE
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got=%b exp=%b", bus.busy, 1'b0);
    end
    $display("single: gnt=0010 done/err seen, back to idle");
  endtask

  task automatic test_round_robin();
    logic [3:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(); // START
      checks++;
      if ({bus.gnt, bus.start} !== {rr_exp[k], 1'b1}) begin
        errors++;
        $display("FAIL rr_grant%0d got=%b exp=%b", k, {bus.gnt, bus.start}, {rr_exp[k], 1'b1});
      end
      step(); // A_PH
      step(); // B_PH
      step(); // WAIT
      bus.xfer_end = 1'b1;
      step(); // GAP 1
      bus.xfer_end = 1'b0;
      checks++;
      if ({bus.done, bus.err} !== 2'b10) begin
        errors++;
        $display("FAIL rr_done%0d got=%b exp=%b", k, {bus.done, bus.err}, 2'b10);
      end
      for (int g = 1; g < GAP_CYC; g++) step();
      step(); // IDLE
      checks++;
      if ({bus.busy, bus.gnt} !== 5'b0) begin
        errors++;
        $display("FAIL rr_idle%0d got=%b exp=%b", k, {bus.busy, bus.gnt}, 5'b0);
      end
      if (k == 4) bus.req = '0;
      $display("rr: transfer %0d gnt=%b", k, rr_exp[k]);
    end
  endtask

  task automatic test_drop_a();
    bus.req        = 4'b0001;
    bus.inj_drop_a = 1'b1;
    step(); // START
    bus.req        = '0;
    bus.inj_drop_a = 1'b0;
    checks++;
    if ({bus.gnt, bus.start} !== 5'b0001_1) begin
      errors++;
      $display("FAIL dropa_start got=%b exp=%b", {bus.gnt, bus.start}, 5'b0001_1);
    end
    step(); // A_PH
    checks++;
    if (bus.a !== 1'b0) begin
      errors++;
      $display("FAIL dropa_a got=%b exp=%b", bus.a, 1'b0);
    end
    step(); // B_PH
    checks++;
    if (bus.b !== 1'b1) begin
      errors++;
      $display("FAIL dropa_b got=%b exp=%b", bus.b, 1'b1);
    end
    step(); // WAIT
    bus.xfer_end = 1'b1;
    bus.prot_err = 1'b1;
    step(); // GAP 1
    bus.xfer_end = 1'b0;
    bus.prot_err = 1'b0;
    checks++;
    if ({bus.done, bus.err} !== 2'b11) begin
      errors++;
      $display("FAIL dropa_done got=%b exp=%b", {bus.done, bus.err}, 2'b11);
    end
    step();
    step(); // IDLE
    $display("drop_a: done=1 err=1");
  endtask

  task automatic test_timeout();
    logic done_early;
    bus.req        = 4'b0100;
    bus.inj_drop_b = 1'b1;
    step(); // START
    bus.req        = '0;
    bus.inj_drop_b = 1'b0;
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL tmo_gnt got=%b exp=%b", bus.gnt, 4'b0100);
    end
    step(); // A_PH
    checks++;
    if (bus.a !== 1'b1) begin
      errors++;
      $display("FAIL tmo_a got=%b exp=%b", bus.a, 1'b1);
    end
    step(); // B_PH, b dropped
    checks++;
    if (bus.b !== 1'b0) begin
      errors++;
      $display("FAIL tmo_dropb got=%b exp=%b", bus.b, 1'b0);
    end
    step(); // WAIT cycle 1
    done_early = bus.done;
    for (int w = 2; w <= TIMEOUT_CYC; w++) begin
      step();
      done_early = done_early | bus.done;
    end
    checks++;
    if (done_early !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early got=%b exp=%b", done_early, 1'b0);
    end
    step(); // GAP 1: TIMEOUT_CYC edges after entering WAIT
    checks++;
    if ({bus.done, bus.err} !== 2'b11) begin
      errors++;
      $display("FAIL tmo_done got=%b exp=%b", {bus.done, bus.err}, 2'b11);
    end
    step();
    step(); // IDLE
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle got=%b exp=%b", bus.busy, 1'b0);
    end
    $display("timeout: done=1 err=1 after %0d wait cycles", TIMEOUT_CYC);
  endtask

  task automatic test_end_at_timeout();
    logic seen;
    bus.req = 4'b1000;
    step(); // START
    bus.req      = '0;
    // Checker activity outside WAIT must be ignored.
    bus.xfer_end = 1'b1;
    bus.prot_err = 1'b1;
    checks++;
    if (bus.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL edge_gnt got=%b exp=%b", bus.gnt, 4'b1000);
    end
    step(); // A_PH
    step(); // B_PH
    seen = bus.done;
    checks++;
    if ({bus.b, seen} !== 2'b10) begin
      errors++;
      $display("FAIL edge_ignore got=%b exp=%b", {bus.b, seen}, 2'b10);
    end
    step(); // WAIT cycle 1
    bus.xfer_end = 1'b0;
    bus.prot_err = 1'b0;
    seen = bus.done;
    for (int w = 2; w <= TIMEOUT_CYC; w++) begin
      step();
      seen = seen | bus.done;
    end
    // Last WAIT cycle: xfer_end coincides with the timeout and wins.
    bus.xfer_end = 1'b1;
    step();
    bus.xfer_end = 1'b0;
    checks++;
    if ({seen, bus.done, bus.err} !== 3'b010) begin
      errors++;
      $display("FAIL edge_done got=%b exp=%b", {seen, bus.done, bus.err}, 3'b010);
    end
    step();
    step(); // IDLE
    $display("end_at_timeout: done=1 err=0");
  endtask

  task automatic test_reset_in_b();
    bus.req = 4'b0001;
    step(); // START
    bus.req = '0;
    step(); // A_PH
    step(); // B_PH
    checks++;
    if ({bus.b, bus.gnt} !== 5'b1_0001) begin
      errors++;
      $display("FAIL rstb_inb got=%b exp=%b", {bus.b, bus.gnt}, 5'b1_0001);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("FAIL rstb_outs got=%b exp=%b", outs, 10'b0);
    end
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    step(); // START of new transfer
    bus.req = '0;
    checks++;
    if ({bus.gnt, bus.start, bus.done} !== 6'b0001_10) begin
      errors++;
      $display("FAIL rstb_regrant got=%b exp=%b", {bus.gnt, bus.start, bus.done}, 6'b0001_10);
    end
    step();
    step();
    step(); // WAIT
    bus.xfer_end = 1'b1;
    step(); // GAP 1
    bus.xfer_end = 1'b0;
    checks++;
    if ({bus.done, bus.err} !== 2'b10) begin
      errors++;
      $display("FAIL rstb_done got=%b exp=%b", {bus.done, bus.err}, 2'b10);
    end
    step();
    step(); // IDLE
    $display("reset_in_b: aborted, regrant=0001");
  endtask

  task automatic test_late_req();
    bus.req = 4'b0100;
    step(); // START
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL late_gnt got=%b exp=%b", bus.gnt, 4'b0100);
    end
    step();
    step();
    step(); // WAIT cycle 1
    bus.req = '0;
    step(); // WAIT cycle 2
    bus.xfer_end = 1'b1;
    step(); // GAP 1
    bus.xfer_end = 1'b0;
    checks++;
    if ({bus.done, bus.err, bus.gnt} !== 6'b10_0100) begin
      errors++;
      $display("FAIL late_done got=%b exp=%b", {bus.done, bus.err, bus.gnt}, 6'b10_0100);
    end
    step(); // GAP 2
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL late_gapbusy got=%b exp=%b", bus.busy, 1'b1);
    end
    step(); // IDLE
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL late_idle got=%b exp=%b", bus.busy, 1'b0);
    end
    step(); // no request pending: stays idle
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("FAIL late_stay got=%b exp=%b", outs, 10'b0);
    end
    $display("late_req: done=1 err=0, busy fell after gap");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop_a();
    test_timeout();
    test_end_at_timeout();
    test_reset_in_b();
    test_late_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
